// File: rtl/spi_burst_ctrl_if.sv
// ----------------------------------------------------------------------------
// spi_burst_ctrl_if
//   Bundles every non-clock signal of spi_burst_ctrl: the CPU-side FIFO
//   access, the burst control/status lines and the single-byte SPI engine
//   handshake.
//   master : the surroundings (register file + spi engine) driving the block
//            tx_push/tx_data/rx_pop/go/abort/spi_data_rx/spi_busy out,
//            status and engine controls in
//   slave  : the burst controller itself (exact mirror of master)
// ----------------------------------------------------------------------------
interface spi_burst_ctrl_if;
  logic       tx_push;
  logic [7:0] tx_data;
  logic       rx_pop;
  logic [7:0] rx_data;
  logic       go;
  logic       abort;
  logic       tx_full;
  logic       rx_empty;
  logic [4:0] tx_count;
  logic [4:0] rx_count;
  logic       ctrl_busy;
  logic       done;
  logic       error;
  logic       cs_n;
  logic       spi_start;
  logic [7:0] spi_data_tx;
  logic [7:0] spi_data_rx;
  logic       spi_busy;

  modport master (
    output tx_push, tx_data, rx_pop, go, abort, spi_data_rx, spi_busy,
    input  rx_data, tx_full, rx_empty, tx_count, rx_count, ctrl_busy,
           done, error, cs_n, spi_start, spi_data_tx
  );

  modport slave (
    input  tx_push, tx_data, rx_pop, go, abort, spi_data_rx, spi_busy,
    output rx_data, tx_full, rx_empty, tx_count, rx_count, ctrl_busy,
           done, error, cs_n, spi_start, spi_data_tx
  );
endinterface

// File: rtl/spi_burst_ctrl.sv
// ----------------------------------------------------------------------------
// spi_burst_ctrl
//   Runs multi-byte SPI bursts through a single-byte spi engine. The CPU
//   queues bytes in a TX FIFO and pulses go; the block drops cs_n, feeds the
//   engine one byte per start/busy handshake, stores each received byte in
//   an RX FIFO and releases cs_n after a hold time.
// Ports
//   raw_clk_i : clock, all logic on the rising edge
//   reset_i   : synchronous active-high reset
//   bus_io    : spi_burst_ctrl_if.slave (FIFO access, go/abort, status,
//               cs_n and the spi engine start/busy/data handshake)
// ----------------------------------------------------------------------------
module spi_burst_ctrl #(
  parameter int DEPTH        = 8,
  parameter int CS_SETUP     = 4,
  parameter int CS_HOLD      = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic            raw_clk_i,
  input  logic            reset_i,
  spi_burst_ctrl_if.slave bus_io
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         CW       = 8;
  localparam logic [4:0] FULL_CNT = 5'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CS_SETUP  = 3'd1,
    S_LOAD      = 3'd2,
    S_START     = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_CAPTURE   = 3'd6,
    S_CS_HOLD   = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            abort_seen_q, abort_seen_d;
  logic            error_q, error_d;
  logic [7:0]      spi_data_tx_q, spi_data_tx_d;
  logic            cs_n_q, spi_start_q, done_q, ctrl_busy_q;

  logic [7:0]      tx_mem_q [DEPTH];
  logic [AW-1:0]   tx_wr_q, tx_rd_q;
  logic [4:0]      tx_cnt_q;
  logic [7:0]      rx_mem_q [DEPTH];
  logic [AW-1:0]   rx_wr_q, rx_rd_q;
  logic [4:0]      rx_cnt_q;

  logic            tx_empty, tx_full, rx_empty, rx_full;
  logic            tx_wr_en, tx_rd_en, tx_flush, rx_wr_en, rx_rd_en;

  assign tx_empty = (tx_cnt_q == 5'd0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == 5'd0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);

  // A flush in the same cycle as a push drops the pushed byte.
  assign tx_wr_en = bus_io.tx_push && !tx_full && !tx_flush;
  assign rx_rd_en = bus_io.rx_pop && !rx_empty;

  // Next-state, counter, sticky flags and FIFO strobes of the burst FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = {CW{1'b0}};
    abort_seen_d  = abort_seen_q | bus_io.abort;
    error_d       = error_q;
    spi_data_tx_d = spi_data_tx_q;
    tx_rd_en      = 1'b0;
    rx_wr_en      = 1'b0;
    tx_flush      = bus_io.abort;
    case (state_q)
      S_IDLE: begin
        abort_seen_d = 1'b0;
        // A simultaneous abort empties the FIFO, so go is not honoured.
        if (bus_io.go && !tx_empty && !bus_io.abort) begin
          state_d = S_CS_SETUP;
          error_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CS_SETUP: begin
        if (bus_io.abort || abort_seen_q) begin
          state_d = S_CS_HOLD;
        end else if (cnt_q == CW'(CS_SETUP - 1)) begin
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOAD: begin
        tx_rd_en      = !tx_empty;
        spi_data_tx_d = tx_mem_q[tx_rd_q];
        state_d       = S_START;
      end
      S_START: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus_io.spi_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          // Engine never acknowledged: give up on the whole burst.
          error_d  = 1'b1;
          tx_flush = 1'b1;
          state_d  = S_CS_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!bus_io.spi_busy) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_CAPTURE: begin
        // With RX full we wait here, cs_n held low, until the CPU pops.
        if (!rx_full) begin
          rx_wr_en = 1'b1;
          if (abort_seen_q || bus_io.abort || tx_empty) begin
            state_d = S_CS_HOLD;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_CS_HOLD: begin
        if (cnt_q == CW'(CS_HOLD - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state plus registered control outputs, all derived from next state.
  always_ff @(posedge raw_clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= {CW{1'b0}};
      abort_seen_q  <= 1'b0;
      error_q       <= 1'b0;
      spi_data_tx_q <= 8'h00;
      cs_n_q        <= 1'b1;
      spi_start_q   <= 1'b0;
      done_q        <= 1'b0;
      ctrl_busy_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      abort_seen_q  <= abort_seen_d;
      error_q       <= error_d;
      spi_data_tx_q <= spi_data_tx_d;
      cs_n_q        <= (state_d == S_IDLE);
      spi_start_q   <= (state_d == S_START);
      done_q        <= (state_q == S_CS_HOLD) && (state_d == S_IDLE);
      ctrl_busy_q   <= (state_d != S_IDLE);
    end
  end

  // TX FIFO pointers and occupancy; flush clears everything at once.
  always_ff @(posedge raw_clk_i) begin
    if (reset_i || tx_flush) begin
      tx_wr_q  <= {AW{1'b0}};
      tx_rd_q  <= {AW{1'b0}};
      tx_cnt_q <= 5'd0;
    end else begin
      if (tx_wr_en) tx_wr_q <= tx_wr_q + AW'(1);
      if (tx_rd_en) tx_rd_q <= tx_rd_q + AW'(1);
      tx_cnt_q <= tx_cnt_q + {4'd0, tx_wr_en} - {4'd0, tx_rd_en};
    end
  end

  // TX FIFO storage.
  always_ff @(posedge raw_clk_i) begin
    if (tx_wr_en) tx_mem_q[tx_wr_q] <= bus_io.tx_data;
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge raw_clk_i) begin
    if (reset_i) begin
      rx_wr_q  <= {AW{1'b0}};
      rx_rd_q  <= {AW{1'b0}};
      rx_cnt_q <= 5'd0;
    end else begin
      if (rx_wr_en) rx_wr_q <= rx_wr_q + AW'(1);
      if (rx_rd_en) rx_rd_q <= rx_rd_q + AW'(1);
      rx_cnt_q <= rx_cnt_q + {4'd0, rx_wr_en} - {4'd0, rx_rd_en};
    end
  end

  // RX FIFO storage.
  always_ff @(posedge raw_clk_i) begin
    if (rx_wr_en) rx_mem_q[rx_wr_q] <= bus_io.spi_data_rx;
  end

  // Head is read straight from the storage registers: no pop latency.
  assign bus_io.rx_data     = rx_mem_q[rx_rd_q];
  assign bus_io.tx_full     = tx_full;
  assign bus_io.rx_empty    = rx_empty;
  assign bus_io.tx_count    = tx_cnt_q;
  assign bus_io.rx_count    = rx_cnt_q;
  assign bus_io.ctrl_busy   = ctrl_busy_q;
  assign bus_io.done        = done_q;
  assign bus_io.error       = error_q;
  assign bus_io.cs_n        = cs_n_q;
  assign bus_io.spi_start   = spi_start_q;
  assign bus_io.spi_data_tx = spi_data_tx_q;

endmodule
